// File: rtl/display_scan_controller_pkg.sv
// display_scan_controller_pkg
// Shared definitions for the 7-segment display scan controller:
//   - FSM state encodings (IDLE, BLANK, SHOW)
//   - digit index constants for the alarm clock display
//   - helper to pick one BCD nibble out of the packed digit word
package display_scan_controller_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    localparam logic [2:0] DIGIT_SEC_UNITS  = 3'd0;
    localparam logic [2:0] DIGIT_SEC_TENS   = 3'd1;
    localparam logic [2:0] DIGIT_MIN_UNITS  = 3'd2;
    localparam logic [2:0] DIGIT_MIN_TENS   = 3'd3;
    localparam logic [2:0] DIGIT_HOUR_UNITS = 3'd4;
    localparam logic [2:0] DIGIT_HOUR_TENS  = 3'd5;

    // Nibble idx of a packed 8-digit BCD word (digit k at [4k+3:4k]).
    function automatic logic [3:0] bcd_nibble(input logic [31:0] word,
                                              input logic [2:0]  idx);
        return word[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/display_scan_controller_scan_slot_timer.sv
// scan_slot_timer
// Per-digit slot timer. Counts 0..TICK_DIV-1 and wraps; decodes the end of the
// blank window and the end of the slot.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   clear         - synchronous clear to 0 (takes priority over run)
//   run           - advance the counter this cycle
//   count         - current position within the slot
//   blank_done    - count is the last blank cycle of the slot
//   slot_done     - count is the last cycle of the slot
module scan_slot_timer #(
    parameter int TICK_DIV     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        run,
    output logic [15:0] count,
    output logic        blank_done,
    output logic        slot_done
);

    assign blank_done = (count == 16'(BLANK_CYCLES - 1));
    assign slot_done  = (count == 16'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= slot_done ? '0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller
// Time-multiplexed scan controller for the alarm clock 7-segment display.
// Walks sel over the digits, blanks the decoder at the start of every slot to
// avoid ghosting, and blinks masked digits while the user edits a value.
// A snapshot of the digits and blink mask is taken at the start of each frame
// so a frame never shows a mix of old and new values.
// Ports:
//   clk, reset_n  - clock, asynchronous active-low reset
//   scan_en       - run scanning; low forces IDLE on the next edge
//   digits_bcd    - packed BCD digits, digit k at [4k+3:4k]
//   blink_en      - global blink enable
//   blink_mask    - bit k set: digit k blinks
//   sel           - 3-to-8 decoder select
//   dec_enable    - decoder enable (SHOW and not blinked off)
//   digit_bcd     - BCD nibble of the selected digit, valid the whole slot
//   frame_done    - pulse on the final SHOW cycle of the last digit
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int TICK_DIV     = 4,
    parameter int BLANK_CYCLES = 1,
    parameter int NUM_DIGITS   = 6,
    parameter int BLINK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scan_en,
    input  logic [31:0] digits_bcd,
    input  logic        blink_en,
    input  logic [7:0]  blink_mask,
    output logic [2:0]  sel,
    output logic        dec_enable,
    output logic [3:0]  digit_bcd,
    output logic        frame_done
);

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic [15:0] slot_count;
    logic        blank_done;
    logic        slot_done;
    logic [31:0] snap_digits;
    logic [7:0]  snap_mask;
    logic [7:0]  frame_count;
    logic        blink_phase;
    logic        last_digit;
    logic        advance;
    logic        reload;
    logic        suppress;

    scan_slot_timer #(
        .TICK_DIV     (TICK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (!scan_en || (state == ST_IDLE)),
        .run        (state != ST_IDLE),
        .count      (slot_count),
        .blank_done (blank_done),
        .slot_done  (slot_done)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (scan_en)    next_state = ST_BLANK;
            ST_BLANK: if (blank_done) next_state = ST_SHOW;
            ST_SHOW:  if (slot_done)  next_state = ST_BLANK;
            default:                  next_state = ST_IDLE;
        endcase
        if (!scan_en) next_state = ST_IDLE;
    end

    assign last_digit = (sel == 3'(NUM_DIGITS - 1));
    assign advance    = scan_en && (state == ST_SHOW) && slot_done;
    // A new frame starts either from IDLE or when the last digit's slot ends.
    assign reload     = scan_en && ((state == ST_IDLE) || (advance && last_digit));
    assign suppress   = blink_en && snap_mask[sel] && !blink_phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sel         <= '0;
            dec_enable  <= 1'b0;
            digit_bcd   <= '0;
            frame_done  <= 1'b0;
            snap_digits <= '0;
            snap_mask   <= '0;
        end else if (!scan_en) begin
            state      <= ST_IDLE;
            sel        <= '0;
            dec_enable <= 1'b0;
            digit_bcd  <= '0;
            frame_done <= 1'b0;
        end else begin
            state <= next_state;
            if (reload) begin
                snap_digits <= digits_bcd;
                snap_mask   <= blink_mask;
                sel         <= '0;
                digit_bcd   <= digits_bcd[3:0];
            end else if (advance) begin
                sel       <= sel + 3'd1;
                digit_bcd <= bcd_nibble(snap_digits, sel + 3'd1);
            end
            dec_enable <= (next_state == ST_SHOW) && !suppress;
            // Registered, so raise it one cycle early: the count about to
            // become the final slot position of the last digit.
            frame_done <= (state != ST_IDLE) && last_digit &&
                          (slot_count == 16'(TICK_DIV - 2));
        end
    end

    // Blink phase keeps running through scan_en drops; only reset clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
            blink_phase <= 1'b1;
        end else if (frame_done) begin
            if (frame_count == 8'(BLINK_FRAMES - 1)) begin
                frame_count <= '0;
                blink_phase <= !blink_phase;
            end else begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller
// Directed bench for display_scan_controller with default parameters:
// a per-cycle vector table over eight frames (scan order, blank/show pattern,
// snapshot behaviour, frame_done, blink), then hand sequences for scan_en
// drop/re-enable and an asynchronous reset in the middle of a SHOW window.
module tb_display_scan_controller;

    logic        clk;
    logic        reset_n;
    logic        scan_en;
    logic [31:0] digits_bcd;
    logic        blink_en;
    logic [7:0]  blink_mask;
    logic [2:0]  sel;
    logic        dec_enable;
    logic [3:0]  digit_bcd;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    display_scan_controller dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_en    (scan_en),
        .digits_bcd (digits_bcd),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .sel        (sel),
        .dec_enable (dec_enable),
        .digit_bcd  (digit_bcd),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        scan_en;
        logic [31:0] digits;
        logic        blink_en;
        logic [7:0]  mask;
        logic [2:0]  sel;
        logic        en;
        logic [3:0]  bcd;
        logic        fd;
    } vec_t;

    localparam int NVEC = 192;
    vec_t vecs[NVEC];

    localparam logic [31:0] DIG_A = 32'h0012_5947;
    localparam logic [31:0] DIG_B = 32'h0023_4510;
    logic [3:0] exp_a[6];
    logic [3:0] exp_b[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [2:0] s, input logic e,
                             input logic [3:0] b, input logic f);
        check({tag, " sel"}, 32'(sel), 32'(s));
        check({tag, " dec_enable"}, 32'(dec_enable), 32'(e));
        check({tag, " digit_bcd"}, 32'(digit_bcd), 32'(b));
        check({tag, " frame_done"}, 32'(frame_done), 32'(f));
    endtask

    initial begin
        exp_a = '{4'd7, 4'd4, 4'd9, 4'd5, 4'd2, 4'd1};
        exp_b = '{4'd0, 4'd1, 4'd5, 4'd4, 4'd3, 4'd2};

        // Cycle c = i+1 counts edges after reset release; slot = (c-1)/4.
        // Frame 0 shows DIG_A (input zeroed during slot 3), frame 1 shows the
        // zeroed input, frames 2+ show DIG_B (changed mid frame 1).
        // Blink phase goes invisible for frames 2,3 and 6,7; blink_en is off
        // for frames 6,7 so only frames 2,3 blank digits 0 and 1.
        for (int i = 0; i < NVEC; i++) begin
            int c, pos, s, f;
            logic supp;
            c   = i + 1;
            pos = (c - 1) % 4;
            s   = ((c - 1) / 4) % 6;
            f   = (c - 1) / 24;
            vecs[i].scan_en  = 1'b1;
            vecs[i].digits   = (c <= 13) ? DIG_A : ((c <= 29) ? 32'h0 : DIG_B);
            vecs[i].blink_en = (f < 6);
            vecs[i].mask     = 8'h03;
            vecs[i].sel      = 3'(s);
            vecs[i].bcd      = (f == 0) ? exp_a[s] : ((f == 1) ? 4'd0 : exp_b[s]);
            supp             = ((f == 2) || (f == 3)) && (s < 2);
            vecs[i].en       = (pos != 0) && !supp;
            vecs[i].fd       = (s == 5) && (pos == 3);
        end

        // Reset with scan_en already high
        reset_n    = 1'b0;
        scan_en    = 1'b1;
        digits_bcd = DIG_A;
        blink_en   = 1'b1;
        blink_mask = 8'h03;
        repeat (3) @(negedge clk);
        check_all("reset", 3'd0, 1'b0, 4'd0, 1'b0);
        reset_n = 1'b1;

        // Table-driven frames
        for (int i = 0; i < NVEC; i++) begin
            scan_en    = vecs[i].scan_en;
            digits_bcd = vecs[i].digits;
            blink_en   = vecs[i].blink_en;
            blink_mask = vecs[i].mask;
            tick();
            check_all($sformatf("c%0d", i + 1), vecs[i].sel, vecs[i].en,
                      vecs[i].bcd, vecs[i].fd);
        end

        // Drop scan_en in the SHOW window of sel=3 (cycle 206, frame shows DIG_B)
        repeat (14) tick();
        check_all("pre-drop", 3'd3, 1'b1, 4'd4, 1'b0);
        scan_en = 1'b0;
        tick();
        check_all("drop", 3'd0, 1'b0, 4'd0, 1'b0);
        digits_bcd = 32'h0000_0008;
        blink_en   = 1'b1;
        blink_mask = 8'h01;
        tick();
        check_all("idle", 3'd0, 1'b0, 4'd0, 1'b0);

        // Re-enable: fresh frame from digit 0 with the new snapshot
        scan_en = 1'b1;
        tick();
        check_all("reen e0", 3'd0, 1'b0, 4'd8, 1'b0);
        for (int e = 1; e <= 57; e++) begin
            tick();
            if (e == 1)  check_all("reen e1", 3'd0, 1'b1, 4'd8, 1'b0);
            if (e == 23) check_all("reen e23", 3'd5, 1'b1, 4'd0, 1'b1);
            if (e == 49) check_all("reen e49 blinked", 3'd0, 1'b0, 4'd8, 1'b0);
            if (e == 57) check_all("reen e57", 3'd2, 1'b1, 4'd0, 1'b0);
        end

        // Asynchronous reset in the middle of SHOW, away from any clock edge
        #2 reset_n = 1'b0;
        #1;
        check_all("async rst", 3'd0, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_all("post rst e1", 3'd0, 1'b0, 4'd8, 1'b0);
        tick();
        // Blink phase must be back to visible, so masked digit 0 shows
        check_all("post rst e2", 3'd0, 1'b1, 4'd8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
